// File: rtl/fastfir_param.sv
// Transposed-form NTAPS FIR with a shift-loaded tap chain, output strobe and taps-loaded flag.
// Optional FASTFIR_TAPOUT_EN exposes the last tap as o_tap so two instances can share one load chain.
module fastfir_param #(
    parameter int NTAPS = 8,
    parameter int IW    = 12,
    parameter int TW    = 12,
    parameter int OW    = IW + TW + $clog2(NTAPS)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_tap_wr,
    input  logic [TW-1:0] i_tap,
    input  logic          i_ce,
    input  logic [IW-1:0] i_sample,
    output logic          o_ce,
    output logic [OW-1:0] o_result,
`ifdef FASTFIR_TAPOUT_EN
    output logic [TW-1:0] o_tap,
`endif
    output logic          o_taps_loaded
);

    localparam int PW = IW + TW;
    localparam int CW = $clog2(NTAPS + 1);
    localparam logic [CW-1:0] NTAPS_C = CW'(NTAPS);

    logic signed [TW-1:0] tap_q  [NTAPS];
    logic signed [TW-1:0] tap_d  [NTAPS];
    logic signed [PW-1:0] prod_q [NTAPS];
    logic signed [PW-1:0] prod_d [NTAPS];
    logic signed [OW-1:0] acc_q  [NTAPS];
    logic signed [OW-1:0] acc_d  [NTAPS];
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 loaded_q, loaded_d;
    logic                 ce_q;
    logic signed [IW-1:0] smp_s;

    assign smp_s = $signed(i_sample);

    always_comb begin
        tap_d    = tap_q;
        prod_d   = prod_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;

        if (i_tap_wr) begin
            tap_d[0] = $signed(i_tap);
            for (int k = 1; k < NTAPS; k++) begin
                tap_d[k] = tap_q[k-1];
            end
            if (cnt_q != NTAPS_C) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        loaded_d = (cnt_d == NTAPS_C);

        // Products sample the taps as they stood before any write in this same cycle.
        if (i_ce) begin
            for (int k = 0; k < NTAPS; k++) begin
                prod_d[k] = PW'(tap_q[k]) * PW'(smp_s);
            end
            acc_d[0] = {{(OW-PW){prod_q[0][PW-1]}}, prod_q[0]};
            for (int k = 1; k < NTAPS; k++) begin
                acc_d[k] = acc_q[k-1] + {{(OW-PW){prod_q[k][PW-1]}}, prod_q[k]};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                tap_q[k]  <= '0;
                prod_q[k] <= '0;
                acc_q[k]  <= '0;
            end
            cnt_q    <= '0;
            loaded_q <= 1'b0;
            ce_q     <= 1'b0;
        end else begin
            tap_q    <= tap_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
            ce_q     <= i_ce;
        end
    end

    assign o_ce          = ce_q;
    assign o_result      = acc_q[NTAPS-1];
    assign o_taps_loaded = loaded_q;
`ifdef FASTFIR_TAPOUT_EN
    assign o_tap         = tap_q[NTAPS-1];
`endif

endmodule

// File: tb/tb_fastfir_param.sv
// Bench for fastfir_param: scoreboard of expected outputs built from a per-sample tap snapshot convolution.
module tb_fastfir_param;

    localparam int NTAPS = 8;
    localparam int IW    = 12;
    localparam int TW    = 12;
    localparam int OW    = IW + TW + $clog2(NTAPS);
    localparam int HMAX  = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tap_wr = 1'b0;
    logic [TW-1:0] tap = '0;
    logic          ce = 1'b0;
    logic [IW-1:0] smp = '0;
    logic          o_ce;
    logic [OW-1:0] res;
    logic          loaded;
`ifdef FASTFIR_TAPOUT_EN
    logic [TW-1:0] o_tap;
`endif

    always #5 clk = ~clk;

    fastfir_param #(.NTAPS(NTAPS), .IW(IW), .TW(TW), .OW(OW)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_tap_wr      (tap_wr),
        .i_tap         (tap),
        .i_ce          (ce),
        .i_sample      (smp),
        .o_ce          (o_ce),
        .o_result      (res),
`ifdef FASTFIR_TAPOUT_EN
        .o_tap         (o_tap),
`endif
        .o_taps_loaded (loaded)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    longint mtap [NTAPS];
    longint hp   [0:HMAX-1][0:NTAPS-1];
    int     nce  = 0;
    int     wcnt = 0;
    longint exp_q [$];
    longint hold  = 0;
    logic   exp_ce = 1'b0;

    // Drive one cycle and advance the model; output for this edge uses samples from earlier edges only.
    task automatic step(input logic r, input logic wr, input int t, input logic c, input int s);
        longint y;
        int idx;
        if (r) begin
            exp_q.delete();
            nce = 0; wcnt = 0; hold = 0; exp_ce = 1'b0;
            for (int k = 0; k < NTAPS; k++) mtap[k] = 0;
        end else begin
            exp_ce = c;
            if (c) begin
                y = 0;
                for (int k = 0; k < NTAPS; k++) begin
                    idx = nce - NTAPS + k;
                    if (idx >= 0 && idx < HMAX) y += hp[idx][k];
                end
                exp_q.push_back(y);
                hold = y;
                if (nce < HMAX) for (int k = 0; k < NTAPS; k++) hp[nce][k] = mtap[k] * longint'(s);
                nce++;
            end
            if (wr) begin
                for (int k = NTAPS-1; k > 0; k--) mtap[k] = mtap[k-1];
                mtap[0] = longint'(t);
                if (wcnt < NTAPS) wcnt++;
            end
        end
        rst = r; tap_wr = wr; tap = TW'(t); ce = c; smp = IW'(s);
        @(posedge clk);
        #1;
        rst = 1'b0; tap_wr = 1'b0; ce = 1'b0;
    endtask

    task automatic test_reset();
        longint y;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 5);
        n_cmp++; if (res !== '0)   begin n_bad++; $display("FAIL reset_result got %0d want 0", $signed(res)); end
        n_cmp++; if (o_ce !== 1'b0) begin n_bad++; $display("FAIL reset_ce got %b want 0", o_ce); end
        n_cmp++; if (loaded !== 1'b0) begin n_bad++; $display("FAIL reset_loaded got %b want 0", loaded); end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1, $urandom_range(0, 4095) - 2048);
            y = exp_q.pop_front();
            n_cmp++; if (o_ce !== 1'b1 || res !== OW'(y) || res !== '0 || loaded !== 1'b0) begin
                n_bad++; $display("FAIL zero_taps ce=%b res=%0d loaded=%b want ce=1 res=%0d loaded=0", o_ce, $signed(res), loaded, y);
            end
        end
    endtask

    task automatic test_impulse();
        longint y;
        int j;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < NTAPS; i++) begin
            step(0, 1, i + 1, 0, 0);
            n_cmp++; if (loaded !== (i == NTAPS-1)) begin n_bad++; $display("FAIL loaded_w%0d got %b want %b", i, loaded, (i == NTAPS-1)); end
        end
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1, (i == 0) ? 1 : 0);
            j = i + 1;
            if (exp_q.size() == 0) begin n_bad++; n_cmp++; $display("FAIL impulse_q empty at %0d", j); continue; end
            y = exp_q.pop_front();
            n_cmp++; if (o_ce !== 1'b1 || res !== OW'(y)) begin n_bad++; $display("FAIL impulse_model edge%0d res=%0d want %0d", j, $signed(res), y); end
            y = (j >= 2 && j <= 9) ? longint'(j - 1) : 0;
            n_cmp++; if (res !== OW'(y)) begin n_bad++; $display("FAIL impulse_table edge%0d res=%0d want %0d", j, $signed(res), y); end
        end
        n_cmp++; if (loaded !== 1'b1) begin n_bad++; $display("FAIL impulse_loaded got %b want 1", loaded); end
    endtask

    task automatic test_full_scale();
        longint y;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < NTAPS; i++) step(0, 1, -2048, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1, -2048);
            y = exp_q.pop_front();
            n_cmp++; if (o_ce !== 1'b1 || res !== OW'(y)) begin n_bad++; $display("FAIL full_scale_model i%0d res=%0d want %0d", i, $signed(res), y); end
        end
        n_cmp++; if (res !== OW'(33554432)) begin n_bad++; $display("FAIL full_scale_final res=%0d want 33554432", $signed(res)); end
    endtask

    task automatic test_ce_gaps();
        longint y;
        longint seen [$];
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < NTAPS; i++) step(0, 1, i + 1, 0, 0);
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 0, (i % 2 == 0), (i == 0) ? 1 : 0);
            n_cmp++; if (o_ce !== exp_ce) begin n_bad++; $display("FAIL gaps_ce cyc%0d got %b want %b", i, o_ce, exp_ce); end
            if (exp_ce) begin
                y = exp_q.pop_front();
                seen.push_back($signed(res));
                n_cmp++; if (res !== OW'(y)) begin n_bad++; $display("FAIL gaps_model cyc%0d res=%0d want %0d", i, $signed(res), y); end
            end else begin
                n_cmp++; if (res !== OW'(hold)) begin n_bad++; $display("FAIL gaps_hold cyc%0d res=%0d want %0d", i, $signed(res), hold); end
            end
        end
        for (int j = 1; j <= 12; j++) begin
            y = (j >= 2 && j <= 9) ? longint'(j - 1) : 0;
            n_cmp++; if (seen[j-1] !== y) begin n_bad++; $display("FAIL gaps_table edge%0d res=%0d want %0d", j, seen[j-1], y); end
        end
    endtask

    task automatic test_wr_with_ce();
        longint y;
        int s;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < NTAPS; i++) step(0, 1, i + 1, 0, 0);
        for (int i = 0; i < 24; i++) begin
            s = (i == 5) ? 1000 : (i == 6) ? -1000 : $urandom_range(0, 4095) - 2048;
            step(0, (i == 5 || i == 9), (i == 5) ? -7 : 300, 1, s);
            y = exp_q.pop_front();
            n_cmp++; if (o_ce !== 1'b1 || res !== OW'(y)) begin n_bad++; $display("FAIL wr_ce_model i%0d res=%0d want %0d", i, $signed(res), y); end
        end
    endtask

    task automatic test_reset_midstream();
        longint y;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < NTAPS; i++) step(0, 1, 100 - i * 30, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1, 700 - i * 200);
            y = exp_q.pop_front();
            n_cmp++; if (res !== OW'(y)) begin n_bad++; $display("FAIL pre_reset i%0d res=%0d want %0d", i, $signed(res), y); end
        end
        step(1, 1, 55, 1, 900);
        n_cmp++; if (res !== '0 || o_ce !== 1'b0 || loaded !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset res=%0d ce=%b loaded=%b want 0 0 0", $signed(res), o_ce, loaded);
        end
        for (int i = 0; i < NTAPS; i++) step(0, 1, i + 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1, (i == 0) ? 1 : 0);
            y = (i + 1 >= 2 && i + 1 <= 9) ? longint'(i) : 0;
            void'(exp_q.pop_front());
            n_cmp++; if (o_ce !== 1'b1 || res !== OW'(y)) begin n_bad++; $display("FAIL rerun edge%0d res=%0d want %0d", i + 1, $signed(res), y); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_full_scale();
        test_ce_gaps();
        test_wr_with_ce();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
